uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: the serial line in, and byte/status outputs.
// The master side (line driver / consumer) drives i_Rx_Serial; the slave side is the receiver.
interface uart_rx_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Active;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Frame_Err,
    input  o_Rx_Active
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Frame_Err,
    output o_Rx_Active
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer feeding a mid-bit sampling FSM.
// Emits a one-cycle DV pulse for a good frame or a one-cycle error pulse when the stop bit is low.
module uart_rx #(
  parameter int CLKS_PER_BIT = 0
) (
  input  logic     i_Clock,
  input  logic     i_Reset,
  uart_rx_if.slave rx
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  localparam logic [12:0] BIT_LAST  = 13'(CLKS_PER_BIT - 1);
  localparam logic [12:0] HALF_LAST = 13'((CLKS_PER_BIT - 1) / 2);

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        err_q, err_d;
  logic        active_q, active_d;
  logic        rx_meta_q;
  logic        rx_s_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    active_d = active_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end

      // A start bit that is no longer low at its mid-point is treated as a glitch.
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            active_d = 1'b1;
            state_d  = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d           = '0;
          shift_d[idx_q]  = rx_s_q;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          active_d = 1'b0;
          state_d  = CLEANUP;
          if (rx_s_q) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      CLEANUP: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
      active_q  <= active_d;
      rx_meta_q <= rx.i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign rx.o_Rx_DV        = dv_q;
  assign rx.o_Rx_Byte      = byte_q;
  assign rx.o_Rx_Frame_Err = err_q;
  assign rx.o_Rx_Active    = active_q;

endmodule
